// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, IR field positions, FSM states.
// Pure declarations; no latency or flow control.
package cpu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   typedef enum logic [3:0] {
      S_IDLE,
      S_T0,
      S_T1,
      S_T1W,
      S_T2,
      S_T3,
      S_T4,
      S_T5,
      S_HALTED
   } state_t;

   typedef enum logic [2:0] {
      K_ADD,
      K_SUB,
      K_AND,
      K_OR,
      K_NOP,
      K_HALT,
      K_ILL
   } op_kind_t;

   function automatic op_kind_t decode_op(input logic [4:0] opc);
      op_kind_t k;
      case (opc)
         OP_ADD:  k = K_ADD;
         OP_SUB:  k = K_SUB;
         OP_AND:  k = K_AND;
         OP_OR:   k = K_OR;
         OP_NOP:  k = K_NOP;
         OP_HALT: k = K_HALT;
         default: k = K_ILL;
      endcase
      return k;
   endfunction

   function automatic logic is_alu_op(input op_kind_t k);
      return (k == K_ADD) || (k == K_SUB) || (k == K_AND) || (k == K_OR);
   endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-bit register field to one-hot select, gated by an enable; purely combinational.
// Zero latency, no flow control; fields beyond NUM_REGS select nothing.
module reg_select_decoder
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16
) (
   input  logic                en,
   input  logic [3:0]          field,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         onehot[i] = en && (int'(field) == i);
      end
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/execute sequencer driving every datapath strobe for three-register ALU instructions.
// ALU ops take 6 cycles, NOP/illegal/HALT 4; fetch stalls in T1W while Mem_ready is low.
module control_unit
   import cpu_pkg::*;
#(
   parameter int NUM_REGS = 16,
   parameter int CNT_W    = 16
) (
   input  logic                Clock,
   input  logic                Resetn,
   input  logic                Run,
   input  logic                Mem_ready,
   input  logic [31:0]         IR,
   output logic                PCout,
   output logic                PCin,
   output logic                IncPC,
   output logic                MARin,
   output logic                MDRin,
   output logic                MDRout,
   output logic                Read,
   output logic                IRin,
   output logic                Yin,
   output logic                Zin,
   output logic                Zlowout,
   output logic                ADD,
   output logic                SUB,
   output logic                AND,
   output logic                OR,
   output logic [NUM_REGS-1:0] Rin,
   output logic [NUM_REGS-1:0] Rout,
   output logic                Running,
   output logic                Halted,
   output logic                Illegal,
   output logic [CNT_W-1:0]    Retired
);

   state_t   state;
   op_kind_t kind;
   logic     alu_op;
   logic     rout_en;
   logic     rin_en;
   logic [3:0] ra, rb, rc;
   logic [3:0] rout_field;
   logic     unused_ir;

   assign kind      = decode_op(IR[OPC_MSB:OPC_LSB]);
   assign alu_op    = is_alu_op(kind);
   assign ra        = IR[RA_MSB:RA_LSB];
   assign rb        = IR[RB_MSB:RB_LSB];
   assign rc        = IR[RC_MSB:RC_LSB];
   assign unused_ir = ^IR[RC_LSB-1:0];

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state   <= S_IDLE;
         Retired <= '0;
      end else begin
         case (state)
            S_IDLE:   if (Run) state <= S_T0;
            S_T0:     state <= S_T1;
            S_T1,
            S_T1W:    state <= Mem_ready ? S_T2 : S_T1W;
            S_T2:     state <= S_T3;
            S_T3: begin
               if (alu_op) begin
                  state <= S_T4;
               end else begin
                  Retired <= Retired + CNT_W'(1);
                  if (kind == K_HALT) state <= S_HALTED;
                  else                state <= Run ? S_T0 : S_IDLE;
               end
            end
            S_T4:     state <= S_T5;
            S_T5: begin
               Retired <= Retired + CNT_W'(1);
               state   <= Run ? S_T0 : S_IDLE;
            end
            S_HALTED: state <= S_HALTED;
            default:  state <= S_IDLE;
         endcase
      end
   end

   // Strobes decode from the state register (and IR, stable from T3) so reset clears them at once.
   always_comb begin
      PCout   = 1'b0;
      PCin    = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      Read    = 1'b0;
      IRin    = 1'b0;
      Yin     = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      ADD     = 1'b0;
      SUB     = 1'b0;
      AND     = 1'b0;
      OR      = 1'b0;
      Illegal = 1'b0;
      case (state)
         S_T0: begin
            PCout = 1'b1;
            MARin = 1'b1;
            IncPC = 1'b1;
            Zin   = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1;
            PCin    = 1'b1;
            Read    = 1'b1;
            MDRin   = 1'b1;
         end
         S_T1W: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Yin     = alu_op;
            Illegal = (kind == K_ILL);
         end
         S_T4: begin
            Zin = 1'b1;
            ADD = (kind == K_ADD);
            SUB = (kind == K_SUB);
            AND = (kind == K_AND);
            OR  = (kind == K_OR);
         end
         S_T5: Zlowout = 1'b1;
         default: ;
      endcase
   end

   assign Running    = (state != S_IDLE) && (state != S_HALTED);
   assign Halted     = (state == S_HALTED);
   assign rout_en    = ((state == S_T3) && alu_op) || (state == S_T4);
   assign rout_field = (state == S_T4) ? rc : rb;
   assign rin_en     = (state == S_T5);

   reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
      .en     (rout_en),
      .field  (rout_field),
      .onehot (Rout)
   );

   reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
      .en     (rin_en),
      .field  (ra),
      .onehot (Rin)
   );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small bus datapath and memory react to the strobes, while a
// per-instruction step schedule built from the opcode table predicts every strobe each cycle.
module tb_control_unit;

   localparam int ST_IDLE = 0, ST_T0 = 1, ST_T1 = 2, ST_T1W = 3, ST_T2 = 4,
                  ST_T3 = 5, ST_T4 = 6, ST_T5 = 7, ST_HALTED = 8;

   typedef struct packed {
      logic pcout, pcin, incpc, marin, mdrin, mdrout, read, irin;
      logic yin, zin, zlowout, add, sub, and_s, or_s;
      logic running, halted, illegal;
      logic [15:0] rin;
      logic [15:0] rout;
   } ctl_t;

   logic Clock = 1'b0;
   always #5 Clock = ~Clock;

   logic        Resetn, Run, Mem_ready;
   logic [31:0] IR;
   logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin, Yin, Zin, Zlowout;
   logic ADD, SUB, AND, OR, Running, Halted, Illegal;
   logic [15:0] Rin, Rout, Retired;

   logic s_PCout, s_PCin, s_IncPC, s_MARin, s_MDRin, s_MDRout, s_Read, s_IRin, s_Yin, s_Zin;
   logic s_Zlowout, s_ADD, s_SUB, s_AND, s_OR, s_Running, s_Halted, s_Illegal;
   logic [15:0] s_Rin, s_Rout;
   logic [2:0]  s_Retired;

   control_unit dut (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .Rin(Rin), .Rout(Rout),
      .Running(Running), .Halted(Halted), .Illegal(Illegal), .Retired(Retired)
   );

   // Narrow counter instance so the retire counter wraps within a short run.
   control_unit #(.NUM_REGS(16), .CNT_W(3)) dut_w3 (
      .Clock(Clock), .Resetn(Resetn), .Run(Run), .Mem_ready(Mem_ready), .IR(IR),
      .PCout(s_PCout), .PCin(s_PCin), .IncPC(s_IncPC), .MARin(s_MARin), .MDRin(s_MDRin),
      .MDRout(s_MDRout), .Read(s_Read), .IRin(s_IRin), .Yin(s_Yin), .Zin(s_Zin),
      .Zlowout(s_Zlowout), .ADD(s_ADD), .SUB(s_SUB), .AND(s_AND), .OR(s_OR),
      .Rin(s_Rin), .Rout(s_Rout), .Running(s_Running), .Halted(s_Halted),
      .Illegal(s_Illegal), .Retired(s_Retired)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   logic [31:0] regs [16];
   logic [31:0] mem  [256];
   logic [31:0] pc, mar, mdr, ir_q, y, z;
   logic [15:0] exp_ret;
   int          pcin_cnt;

   assign IR = ir_q;

   function automatic ctl_t sample();
      ctl_t c;
      c = '{pcout:PCout, pcin:PCin, incpc:IncPC, marin:MARin, mdrin:MDRin, mdrout:MDRout,
            read:Read, irin:IRin, yin:Yin, zin:Zin, zlowout:Zlowout, add:ADD, sub:SUB,
            and_s:AND, or_s:OR, running:Running, halted:Halted, illegal:Illegal,
            rin:Rin, rout:Rout};
      return c;
   endfunction

   function automatic bit is_alu(input logic [31:0] w);
      return w[31:27] inside {5'b00011, 5'b00100, 5'b00101, 5'b00110};
   endfunction

   function automatic bit is_ill(input logic [31:0] w);
      return !is_alu(w) && !(w[31:27] inside {5'b11010, 5'b11011});
   endfunction

   function automatic ctl_t exp_ctl(input int st, input logic [31:0] w);
      ctl_t c;
      logic [15:0] one;
      c   = '0;
      one = 16'd1;
      case (st)
         ST_T0:  begin c.pcout = 1; c.marin = 1; c.incpc = 1; c.zin = 1; end
         ST_T1:  begin c.zlowout = 1; c.pcin = 1; c.read = 1; c.mdrin = 1; end
         ST_T1W: begin c.read = 1; c.mdrin = 1; end
         ST_T2:  begin c.mdrout = 1; c.irin = 1; end
         ST_T3: begin
            if (is_alu(w)) begin c.rout = one << w[22:19]; c.yin = 1; end
            c.illegal = is_ill(w);
         end
         ST_T4: begin
            c.rout  = one << w[18:15];
            c.zin   = 1;
            c.add   = (w[31:27] == 5'b00011);
            c.sub   = (w[31:27] == 5'b00100);
            c.and_s = (w[31:27] == 5'b00101);
            c.or_s  = (w[31:27] == 5'b00110);
         end
         ST_T5:     begin c.zlowout = 1; c.rin = one << w[26:23]; end
         ST_HALTED: c.halted = 1;
         default: ;
      endcase
      c.running = (st >= ST_T0) && (st <= ST_T5);
      return c;
   endfunction

   function automatic int oh_idx(input logic [15:0] v);
      int r = 0;
      for (int i = 0; i < 16; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Datapath/memory environment: performs the loads the observed strobes request.
   task automatic dp_update(input ctl_t s, input logic rdy);
      logic [31:0] bus;
      if (s.pcout)        bus = pc;
      else if (s.zlowout) bus = z;
      else if (s.mdrout)  bus = mdr;
      else if (|s.rout)   bus = regs[oh_idx(s.rout)];
      else                bus = 32'd0;
      if (s.mdrin && s.read && rdy) mdr = mem[mar[7:0]];
      if (s.marin) mar  = bus;
      if (s.pcin)  pc   = bus;
      if (s.yin)   y    = bus;
      if (s.irin)  ir_q = bus;
      if (s.zin) begin
         if (s.incpc)      z = bus + 32'd1;
         else if (s.add)   z = y + bus;
         else if (s.sub)   z = y - bus;
         else if (s.and_s) z = y & bus;
         else if (s.or_s)  z = y | bus;
         else              z = bus;
      end
      if (|s.rin) regs[oh_idx(s.rin)] = bus;
   endtask

   task automatic step(input int st, input logic [31:0] w, input logic run_v, input logic rdy_v);
      ctl_t got;
      @(negedge Clock);
      got = sample();
      check($sformatf("ctl_step%0d", st), 64'(got), 64'(exp_ctl(st, w)));
      check("retired", 64'(Retired), 64'(exp_ret));
      check("retired_w3", 64'(s_Retired), 64'(exp_ret[2:0]));
      if (got.pcin) pcin_cnt++;
      Run       = run_v;
      Mem_ready = rdy_v;
      @(posedge Clock);
      #1;
      dp_update(got, rdy_v);
   endtask

   task automatic async_reset_check(input string tag);
      #2 Resetn = 1'b0;
      #1;
      check({tag, "_ctl"}, 64'(sample()), 64'd0);
      check({tag, "_ret"}, 64'(Retired), 64'd0);
      check({tag, "_ret_w3"}, 64'(s_Retired), 64'd0);
      exp_ret = '0;
      @(posedge Clock);
      #1 Resetn = 1'b1;
   endtask

   // One instruction from T0; abort_at >= 0 applies reset during that step instead.
   task automatic run_instr(input logic [31:0] w, input int stalls, input logic run_next,
                            input int abort_at);
      int          steps[$];
      logic [31:0] a, b, res, pc0;
      steps = '{ST_T0, ST_T1};
      for (int i = 0; i < stalls; i++) steps.push_back(ST_T1W);
      steps.push_back(ST_T2);
      steps.push_back(ST_T3);
      if (is_alu(w)) begin steps.push_back(ST_T4); steps.push_back(ST_T5); end
      mem[pc[7:0]] = w;
      pc0 = pc;
      pcin_cnt = 0;
      a = regs[w[22:19]];
      b = regs[w[18:15]];
      case (w[31:27])
         5'b00011: res = a + b;
         5'b00100: res = a - b;
         5'b00101: res = a & b;
         default:  res = a | b;
      endcase
      for (int i = 0; i < steps.size(); i++) begin
         logic rdy, rn;
         if (i == abort_at) begin
            @(negedge Clock);
            check("pre_reset_ctl", 64'(sample()), 64'(exp_ctl(steps[i], w)));
            async_reset_check("midinstr_reset");
            return;
         end
         rdy = (steps[i] == ST_T1 || steps[i] == ST_T1W) ? (i == 1 + stalls) : 1'($urandom);
         rn  = (i == steps.size() - 1) ? run_next : 1'($urandom);
         step(steps[i], w, rn, rdy);
      end
      exp_ret = exp_ret + 16'd1;
      check("pcin_once", 64'(pcin_cnt), 64'd1);
      check("pc_inc", 64'(pc), 64'(pc0 + 32'd1));
      check("ir_fetch", 64'(ir_q), 64'(w));
      if (is_alu(w)) check("alu_result", 64'(regs[w[26:23]]), 64'(res));
   endtask

   function automatic logic [31:0] mk(input logic [4:0] op);
      return {op, 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] w;
      logic        rn;
      Resetn = 1'b0; Run = 1'b0; Mem_ready = 1'b0;
      for (int i = 0; i < 16; i++) regs[i] = $urandom;
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      pc = 0; mar = 0; mdr = 0; ir_q = 0; y = 0; z = 0; exp_ret = 0; pcin_cnt = 0;
      #12;
      check("reset_ctl", 64'(sample()), 64'd0);
      check("reset_ret", 64'(Retired), 64'd0);
      @(posedge Clock);
      #1 Resetn = 1'b1;

      step(ST_IDLE, 0, 1'b0, 1'b1);
      step(ST_IDLE, 0, 1'b1, 1'b0);
      regs[2] = 32'h12; regs[3] = 32'h14;
      run_instr(32'h28918000, 0, 1'b0, -1);
      check("and_r1", 64'(regs[1]), 64'h10);

      step(ST_IDLE, 0, 1'b1, 1'b1);
      run_instr(mk(5'b00011), 3, 1'b0, -1);

      step(ST_IDLE, 0, 1'b1, 1'b0);
      run_instr(mk(5'b00011), 0, 1'b1, -1);
      run_instr(mk(5'b00100), 1, 1'b1, -1);
      run_instr(mk(5'b00110), 0, 1'b0, -1);
      step(ST_IDLE, 0, 1'b1, 1'b1);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 5))
            0: w = mk(5'b00011);
            1: w = mk(5'b00100);
            2: w = mk(5'b00101);
            3: w = mk(5'b00110);
            4: w = mk(5'b11010);
            default: begin
               w = mk(5'($urandom));
               while (!is_ill(w)) w = mk(5'($urandom));
            end
         endcase
         rn = 1'($urandom);
         run_instr(w, $urandom_range(0, 3), rn, -1);
         if (!rn) begin
            if ($urandom_range(0, 1) == 1) step(ST_IDLE, 0, 1'b0, 1'($urandom));
            step(ST_IDLE, 0, 1'b1, 1'($urandom));
         end
      end

      run_instr(mk(5'b11111), 1, 1'b1, -1);
      run_instr(mk(5'b11011), 0, 1'b1, -1);
      for (int n = 0; n < 5; n++) step(ST_HALTED, 0, 1'($urandom), 1'($urandom));
      @(negedge Clock);
      async_reset_check("halted_reset");

      step(ST_IDLE, 0, 1'b1, 1'b1);
      run_instr(mk(5'b00101), 1, 1'b1, 5);
      step(ST_IDLE, 0, 1'b1, 1'b1);
      run_instr(mk(5'b00011), 0, 1'b0, -1);
      step(ST_IDLE, 0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
